// File: rtl/draw_pkg.sv
// draw_pkg: shared state encoding, datapath defaults and one-hot helper for the sprite draw scheduler
package draw_pkg;
  localparam int X_W_DEF = 9;
  localparam int Y_W_DEF = 8;
  localparam int C_W_DEF = 3;
  localparam int TRANSP_DEF = 0;
  typedef enum logic [2:0] {IDLE, CLEAR, DRAW, FLUSH, RELEASE} state_t;
  function automatic logic [2:0] oh_idx(input logic [7:0] oh);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
    return r;
  endfunction
endpackage

// File: rtl/sprite_draw_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first request at or after the rotating pointer
module rr_arbiter #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);
  // walk from farthest to nearest so the closest request overwrites
  always_comb begin
    gnt = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N]) gnt = N'(1) << ((int'(ptr) + i) % N);
  end
endmodule

// File: rtl/sprite_draw_scheduler.sv
// sprite_draw_scheduler: round-robin owner of the single plot port, sequencing drawers and aligning x/y to ROM colour
module sprite_draw_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int X_W = draw_pkg::X_W_DEF,
  parameter int Y_W = draw_pkg::Y_W_DEF,
  parameter int C_W = draw_pkg::C_W_DEF,
  parameter int ROM_LAT = 1,
  parameter int MAX_CYC = 16384,
  parameter int TRANSP = draw_pkg::TRANSP_DEF
) (
  input  logic                   clock_all,
  input  logic                   reset_all,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     drw_done,
  input  logic [NUM_REQ*X_W-1:0] drw_x,
  input  logic [NUM_REQ*Y_W-1:0] drw_y,
  input  logic [NUM_REQ*C_W-1:0] drw_colour,
  output logic [NUM_REQ-1:0]     drw_enable,
  output logic [NUM_REQ-1:0]     drw_reset_n,
  output logic [NUM_REQ-1:0]     grant,
  output logic [X_W-1:0]         vga_x,
  output logic [Y_W-1:0]         vga_y,
  output logic [C_W-1:0]         vga_colour,
  output logic                   vga_plot,
  output logic                   busy,
  output logic                   served,
  output logic                   aborted
);
  import draw_pkg::*;
  localparam int PW = $clog2(NUM_REQ);
  localparam int WW = $clog2(MAX_CYC);
  state_t state;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PW-1:0] ptr, idx;
  logic [WW-1:0] wd;
  logic ok;
  logic [X_W-1:0] px [ROM_LAT];
  logic [Y_W-1:0] py [ROM_LAT];
  logic [ROM_LAT-1:0] pv;
  logic [X_W-1:0] x_sel;
  logic [Y_W-1:0] y_sel;
  logic [C_W-1:0] c_sel;
  rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (.req(req), .ptr(ptr), .gnt(gnt_c));
  assign idx = PW'(oh_idx(8'(grant)));
  assign x_sel = drw_x[int'(idx)*X_W +: X_W];
  assign y_sel = drw_y[int'(idx)*Y_W +: Y_W];
  assign c_sel = drw_colour[int'(idx)*C_W +: C_W];
  // the drawer's counter clear is released exactly while it is enabled
  assign drw_reset_n = drw_enable;
  assign busy = state != IDLE;
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      state <= IDLE;
      grant <= '0;
      drw_enable <= '0;
      ptr <= '0;
      wd <= '0;
      ok <= 1'b0;
      served <= 1'b0;
      aborted <= 1'b0;
    end else begin
      served <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          grant <= gnt_c;
          state <= CLEAR;
        end
        CLEAR: begin
          wd <= '0;
          drw_enable <= grant;
          state <= DRAW;
        end
        DRAW: begin
          wd <= wd + 1'b1;
          if (drw_done[idx] || wd == WW'(MAX_CYC - 1)) begin
            ok <= drw_done[idx];
            wd <= '0;
            drw_enable <= '0;
            state <= FLUSH;
          end
        end
        // watchdog counter doubles as the flush timer
        FLUSH: begin
          wd <= wd + 1'b1;
          if (wd == WW'(ROM_LAT - 1)) begin
            served <= ok;
            aborted <= !ok;
            state <= RELEASE;
          end
        end
        default: begin
          grant <= '0;
          ptr <= idx == PW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clock_all) begin
    if (reset_all) begin
      px <= '{default: '0};
      py <= '{default: '0};
      pv <= '0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      vga_plot <= 1'b0;
    end else begin
      px[0] <= x_sel;
      py[0] <= y_sel;
      pv[0] <= state == DRAW;
      for (int i = 1; i < ROM_LAT; i++) begin
        px[i] <= px[i-1];
        py[i] <= py[i-1];
        pv[i] <= pv[i-1];
      end
      vga_plot <= pv[ROM_LAT-1] && c_sel != C_W'(TRANSP);
      if (pv[ROM_LAT-1]) begin
        vga_x <= px[ROM_LAT-1];
        vga_y <= py[ROM_LAT-1];
        vga_colour <= c_sel;
      end
    end
  end
endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb_sprite_draw_scheduler: directed scenarios with bench drawers and a per-grant pixel model checked every cycle
module tb_sprite_draw_scheduler;
  localparam int NR = 4, XW = 9, YW = 8, CW = 3, RL = 1, MC = 4000;
  logic clk = 0, reset_all = 1;
  logic [NR-1:0] req = '0, drw_done, drw_enable, drw_reset_n, grant;
  logic [NR*XW-1:0] drw_x;
  logic [NR*YW-1:0] drw_y;
  logic [NR*CW-1:0] drw_colour;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic vga_plot, busy, served, aborted;
  int tests = 0, fails = 0, cyc = 0;
  int dw[NR] = '{1, 1, 1, 1}, dh[NR] = '{1, 1, 1, 1}, dx[NR] = '{0, 0, 0, 0}, dy[NR] = '{0, 0, 0, 0};
  bit nd[NR] = '{0, 0, 0, 0};
  bit cmode = 0;
  int addr[NR] = '{0, 0, 0, 0};
  logic [CW-1:0] q[NR];
  typedef struct {int cyc; int x; int y; int c;} px_t;
  px_t pq[$];
  int glog[$], rlog[$];
  int pl_n = 0, sv_n = 0, ab_n = 0, en_n = 0, lx = 0, ly = 0, ab_cyc = 0;
  bit armed = 0, prv_rst = 0, act = 0, kind = 0;
  int g = 0, n = 0, c0 = 0, rel = 0;
  logic [NR-1:0] prv_grant = '0;
  sprite_draw_scheduler #(.NUM_REQ(NR), .X_W(XW), .Y_W(YW), .C_W(CW), .ROM_LAT(RL), .MAX_CYC(MC), .TRANSP(0)) dut (
    .clock_all(clk), .reset_all(reset_all), .req(req), .drw_done(drw_done), .drw_x(drw_x), .drw_y(drw_y),
    .drw_colour(drw_colour), .drw_enable(drw_enable), .drw_reset_n(drw_reset_n), .grant(grant),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy),
    .served(served), .aborted(aborted)
  );
  always #5 clk = ~clk;
  function automatic logic [CW-1:0] col(int i, int k);
    return cmode ? CW'((k + i) % 8) : CW'(1 + (k + i) % 7);
  endfunction
  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  // drawMeowth-style drawers: address counter plus registered ROM colour
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NR; i++) begin
      addr[i] <= !drw_reset_n[i] ? 0 : drw_enable[i] ? addr[i] + 1 : addr[i];
      q[i] <= col(i, addr[i]);
    end
  end
  for (genvar j = 0; j < NR; j++) begin : g_drw
    assign drw_x[j*XW +: XW] = XW'(dx[j] + addr[j] % dw[j]);
    assign drw_y[j*YW +: YW] = YW'(dy[j] + (addr[j] / dw[j]) % dh[j]);
    assign drw_colour[j*CW +: CW] = q[j];
    assign drw_done[j] = !nd[j] && addr[j] == dw[j] * dh[j] - 1;
  end
  always @(negedge clk) begin
    if (prv_rst) begin
      chk("rst_grant", int'(grant), 0);
      chk("rst_enable", int'(drw_enable), 0);
      chk("rst_reset_n", int'(drw_reset_n), 0);
      chk("rst_vga", int'({vga_x, vga_y, vga_colour, vga_plot}), 0);
      chk("rst_flags", int'({busy, served, aborted}), 0);
      pq.delete();
      act = 0;
      armed = 1;
    end else if (armed) begin
      if (drw_enable != 0 && !(act && cyc < c0 + n)) begin
        chk("enable_onehot", int'($onehot(drw_enable)), 1);
        chk("clear_cycle_grant", int'(prv_grant), int'(drw_enable));
        if (act) chk("no_overlap", int'(cyc >= rel + 3), 1);
        for (int i = 0; i < NR; i++) if (drw_enable[i]) g = i;
        c0 = cyc;
        kind = !nd[g] && dw[g] * dh[g] <= MC;
        n = kind ? dw[g] * dh[g] : MC;
        rel = c0 + n + RL;
        act = 1;
        for (int k = 0; k < n; k++)
          if (col(g, k) != 0) pq.push_back('{c0 + k + RL + 1, dx[g] + k % dw[g], dy[g] + (k / dw[g]) % dh[g], int'(col(g, k))});
        glog.push_back(g);
        rlog.push_back(cyc);
      end
      chk("enable", int'(drw_enable), (act && cyc < c0 + n) ? 1 << g : 0);
      chk("reset_n", int'(drw_reset_n), (act && cyc < c0 + n) ? 1 << g : 0);
      if (act && cyc <= rel) chk("grant_held", int'({grant, busy}), ((1 << g) << 1) | 1);
      if (act && cyc == rel + 1) chk("grant_released", int'({grant, busy}), 0);
      chk("served", int'(served), int'(act && cyc == rel && kind));
      chk("aborted", int'(aborted), int'(act && cyc == rel && !kind));
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
        chk("plot", int'(vga_plot), 1);
        chk("plot_x", int'(vga_x), pq[0].x);
        chk("plot_y", int'(vga_y), pq[0].y);
        chk("plot_colour", int'(vga_colour), pq[0].c);
        void'(pq.pop_front());
      end else chk("no_plot", int'(vga_plot), 0);
      if (vga_plot) begin
        pl_n++;
        lx = int'(vga_x);
        ly = int'(vga_y);
      end
      if (served) sv_n++;
      if (aborted) begin
        ab_n++;
        ab_cyc = cyc;
      end
      if (drw_enable != 0) en_n++;
    end
    prv_rst = reset_all;
    prv_grant = grant;
  end
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset_all = 1;
    req = '0;
    tick(2);
    reset_all = 0;
    pl_n = 0; sv_n = 0; ab_n = 0; en_n = 0;
    glog.delete();
    rlog.delete();
  endtask
  task automatic wait_grants(input int cnt, input int lim, input string nm);
    int k = 0;
    while (glog.size() < cnt && k < lim) begin
      tick(1);
      k++;
    end
    chk(nm, int'(glog.size() >= cnt), 1);
  endtask
  task automatic wait_rel(input int cnt, input int lim, input string nm);
    int k = 0;
    while (sv_n + ab_n < cnt && k < lim) begin
      tick(1);
      k++;
    end
    chk(nm, int'(sv_n + ab_n >= cnt), 1);
  endtask
  initial begin
    int exp_g[5] = '{0, 1, 2, 3, 0};
    // single 61x63 sprite: every pixel plotted, last one at the done coordinate
    do_reset();
    dw[1] = 61; dh[1] = 63; dx[1] = 10; dy[1] = 5;
    req = 4'b0010;
    wait_grants(1, 10, "t1_grant_wait");
    req = '0;
    wait_rel(1, 5000, "t1_release_wait");
    tick(3);
    chk("t1_granted", glog[0], 1);
    chk("t1_plots", pl_n, 3843);
    chk("t1_served", sv_n, 1);
    chk("t1_aborted", ab_n, 0);
    chk("t1_last_x", lx, 70);
    chk("t1_last_y", ly, 67);
    // all request together: strict rotation, fixed 8-cycle spacing for 2x2 sprites
    do_reset();
    for (int i = 0; i < NR; i++) begin
      dw[i] = 2; dh[i] = 2; dx[i] = 100 + 4 * i; dy[i] = 4 * i;
    end
    req = 4'b1111;
    wait_grants(5, 100, "t2_grant_wait");
    req = '0;
    wait_rel(5, 100, "t2_release_wait");
    tick(3);
    for (int i = 0; i < 5; i++) chk("t2_order", glog[i], exp_g[i]);
    for (int i = 0; i < 4; i++) chk("t2_spacing", rlog[i+1] - rlog[i], 8);
    chk("t2_served", sv_n, 5);
    chk("t2_plots", pl_n, 20);
    // drawer 2 never finishes: watchdog abort, pointer still advances to 3
    do_reset();
    dw[2] = 50; dh[2] = 50; dx[2] = 0; dy[2] = 0; nd[2] = 1;
    req = 4'b0100;
    wait_grants(1, 10, "t3_grant_wait");
    req = '0;
    wait_rel(1, 4100, "t3_abort_wait");
    tick(2);
    chk("t3_aborted", ab_n, 1);
    chk("t3_served", sv_n, 0);
    chk("t3_plots", pl_n, 4000);
    chk("t3_abort_time", ab_cyc - rlog[0], 4001);
    nd[2] = 0;
    req = 4'b1010;
    wait_grants(2, 20, "t3_next_wait");
    req = '0;
    wait_rel(2, 50, "t3_next_release");
    chk("t3_rr_next", glog[1], 3);
    // transparent key: colour k%8 hides pixels 0 and 8 of a 4x3 sprite
    do_reset();
    cmode = 1;
    dw[0] = 4; dh[0] = 3; dx[0] = 200; dy[0] = 100;
    req = 4'b0001;
    wait_grants(1, 10, "t4_grant_wait");
    req = '0;
    wait_rel(1, 40, "t4_release_wait");
    tick(2);
    chk("t4_plots", pl_n, 10);
    chk("t4_draw_cycles", en_n, 12);
    chk("t4_last_x", lx, 203);
    chk("t4_last_y", ly, 102);
    cmode = 0;
    // reset in the middle of drawer 2's draw
    do_reset();
    dw[2] = 20; dh[2] = 20;
    req = 4'b0100;
    wait_grants(1, 10, "t5_grant_wait");
    tick(10);
    reset_all = 1;
    req = '0;
    tick(2);
    reset_all = 0;
    tick(5);
    chk("t5_no_pulse", sv_n + ab_n, 0);
    chk("t5_no_regrant", glog.size(), 1);
    // requester drops mid-draw while another arrives
    do_reset();
    dw[2] = 3; dh[2] = 3; dw[3] = 2; dh[3] = 5; dx[3] = 50; dy[3] = 60;
    req = 4'b0100;
    wait_grants(1, 10, "t6_grant_wait");
    req = 4'b1000;
    wait_grants(2, 40, "t6_second_wait");
    req = '0;
    wait_rel(2, 60, "t6_release_wait");
    tick(2);
    chk("t6_first", glog[0], 2);
    chk("t6_second", glog[1], 3);
    chk("t6_spacing", rlog[1] - rlog[0], 13);
    chk("t6_served", sv_n, 2);
    chk("t6_plots", pl_n, 19);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1);
  end
endmodule
